// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register: owns the PC, issues instruction fetches,
// and applies EX-stage redirects with optional MIPS delay-slot preservation.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b1,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic [15:0] squash_cnt
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [15:0] squash_q, squash_d;
    logic [1:0]  squash_inc;

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // A redirect always discards the IF fetch; without a delay slot the ID instruction dies too.
    assign squash_inc = 2'd1 + {1'b0, (DELAY_SLOT == 1'b0) && valid_q};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;
        squash_d = squash_q;
        if (redirect) begin
            pc_d     = redirect_target & 32'hFFFF_FFFC;
            state_d  = ST_FETCH;
            squash_d = sat_add(squash_q, squash_inc);
            if (DELAY_SLOT == 1'b0) begin
                valid_d = 1'b0;
                instr_d = NOP_WORD;
            end
        end else if (!stall) begin
            case (state_q)
                ST_FETCH: if (!imem_ready) state_d = ST_WAIT;
                default:  if (imem_ready)  state_d = ST_FETCH;
            endcase
            if (imem_ready) begin
                instr_d = imem_rdata;
                pc4_d   = pc_q + 32'd4;
                valid_d = 1'b1;
                pc_d    = pc_q + 32'd4;
            end else begin
                valid_d = 1'b0;
                instr_d = NOP_WORD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= NOP_WORD;
            pc4_q    <= 32'h0000_0000;
            squash_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
            squash_q <= squash_d;
        end
    end

    assign imem_addr      = pc_q;
    assign imem_req       = rst_n;
    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign squash_cnt     = squash_q;

endmodule
